// File: rtl/binary_to_bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
// The master drives start/binary_in; the slave (converter) returns status and result.
interface binary_to_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);

  logic                  start;
  logic [WIDTH-1:0]      binary_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  overflow;
  logic                  sign_out;

  modport master (
    output start,
    output binary_in,
    input  busy,
    input  done,
    input  bcd_out,
    input  overflow,
    input  sign_out
  );

  modport slave (
    input  start,
    input  binary_in,
    output busy,
    output done,
    output bcd_out,
    output overflow,
    output sign_out
  );

endinterface

// File: rtl/binary_to_bcd_seq.sv
// Multi-cycle binary to packed-BCD converter (shift-and-add-3, one bit per clock).
// A conversion accepted on edge k completes on edge k+WIDTH with a one-cycle done
// pulse; results that do not fit in DIGITS digits saturate to all nines.
// Optional macro BCD_SIGNED_INPUT_EN: treat binary_in as two's complement, convert
// its magnitude and report the sign on sign_out. Without it sign_out is tied to 0.
module binary_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  binary_to_bcd_seq_if.slave  bus
);

  // Extra digits above the visible ones so no intermediate carry is ever dropped
  localparam int HEAD_DIGITS = (WIDTH * 302 + 999) / 1000 + 1;
  localparam int ALL_DIGITS  = DIGITS + HEAD_DIGITS;
  localparam int DIG_W       = 4 * ALL_DIGITS;
  localparam int OUT_W       = 4 * DIGITS;
  localparam int CNT_W       = $clog2(WIDTH + 1);
  localparam int CMP_W       = ((WIDTH > OUT_W) ? WIDTH : OUT_W) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(WIDTH);
  localparam logic [OUT_W-1:0] ALL_NINES = {DIGITS{4'h9}};

  // 10**n evaluated at elaboration; 10**DIGITS < 16**DIGITS always fits in CMP_W bits
  function automatic logic [CMP_W-1:0] pow10(input int n);
    logic [CMP_W-1:0] p;
    p = CMP_W'(1);
    for (int i = 0; i < n; i++) begin
      p = p * CMP_W'(10);
    end
    return p;
  endfunction

  localparam logic [CMP_W-1:0] LIMIT = pow10(DIGITS);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     shift_reg;
  logic [DIG_W-1:0]     digit_reg;
  logic [CNT_W-1:0]     count;
  logic                 ovf_pending;
  logic                 busy_r;
  logic                 done_r;
  logic [OUT_W-1:0]     bcd_r;
  logic                 ovf_r;

  logic [WIDTH-1:0]     magnitude;
  logic                 ovf_now;
  logic [DIG_W-1:0]     adjusted;
  logic [DIG_W-1:0]     next_digits;
  logic [WIDTH-1:0]     next_shift;

`ifdef BCD_SIGNED_INPUT_EN
  logic                 sign_pending;
  logic                 sign_r;

  // Two's complement magnitude; the most negative value maps onto itself as unsigned
  always_comb begin
    magnitude = bus.binary_in[WIDTH-1] ? (-bus.binary_in) : bus.binary_in;
  end
`else
  // Unsigned input: the value is its own magnitude
  always_comb begin
    magnitude = bus.binary_in;
  end
`endif

  // Saturation decision made once at capture, while the full binary value is at hand
  always_comb begin
    ovf_now = (CMP_W'(magnitude) >= LIMIT);
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit
  always_comb begin
    adjusted = digit_reg;
    for (int i = 0; i < ALL_DIGITS; i++) begin
      if (digit_reg[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = digit_reg[4*i +: 4] + 4'd3;
      end
    end
    next_digits = {adjusted[DIG_W-2:0], shift_reg[WIDTH-1]};
    next_shift  = {shift_reg[WIDTH-2:0], 1'b0};
  end

  // Control FSM with registered outputs: capture in IDLE, iterate WIDTH times in SHIFT
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      digit_reg   <= '0;
      count       <= '0;
      ovf_pending <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      bcd_r       <= '0;
      ovf_r       <= 1'b0;
`ifdef BCD_SIGNED_INPUT_EN
      sign_pending <= 1'b0;
      sign_r       <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shift_reg   <= magnitude;
            digit_reg   <= '0;
            count       <= CNT_LOAD;
            ovf_pending <= ovf_now;
            busy_r      <= 1'b1;
            state       <= SHIFT;
`ifdef BCD_SIGNED_INPUT_EN
            sign_pending <= bus.binary_in[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          digit_reg <= next_digits;
          shift_reg <= next_shift;
          count     <= count - CNT_ONE;
          if (count == CNT_ONE) begin
            bcd_r  <= ovf_pending ? ALL_NINES : next_digits[OUT_W-1:0];
            ovf_r  <= ovf_pending;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= IDLE;
`ifdef BCD_SIGNED_INPUT_EN
            sign_r <= sign_pending;
`endif
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.bcd_out  = bcd_r;
  assign bus.overflow = ovf_r;
`ifdef BCD_SIGNED_INPUT_EN
  assign bus.sign_out = sign_r;
`else
  assign bus.sign_out = 1'b0;
`endif

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// Self-checking bench for binary_to_bcd_seq: three instances (8b/3 digits,
// 8b/2 digits, 16b/5 digits) checked against an arithmetic decimal model.
module tb_binary_to_bcd_seq;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  binary_to_bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) a_if ();
  binary_to_bcd_seq_if #(.WIDTH(8),  .DIGITS(2)) b_if ();
  binary_to_bcd_seq_if #(.WIDTH(16), .DIGITS(5)) c_if ();

  binary_to_bcd_seq #(.WIDTH(8),  .DIGITS(3)) dut_a (.clk(clk), .reset(reset), .bus(a_if));
  binary_to_bcd_seq #(.WIDTH(8),  .DIGITS(2)) dut_b (.clk(clk), .reset(reset), .bus(b_if));
  binary_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut_c (.clk(clk), .reset(reset), .bus(c_if));

  // Free-running clock
  always #5 clk = ~clk;

  // Single comparison point: counts, and reports any difference
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Decimal reference: plain division by ten, saturating to all nines
  function automatic logic [63:0] refBcd(input longint unsigned raw, input int w, input int d,
                                         output logic ovf, output logic sgn);
    longint unsigned mag;
    longint unsigned lim;
    logic [63:0]     res;
    mag = raw;
    sgn = 1'b0;
`ifdef BCD_SIGNED_INPUT_EN
    if (((raw >> (w - 1)) & 64'd1) == 64'd1) begin
      sgn = 1'b1;
      mag = (64'd1 << w) - raw;
    end
`endif
    lim = 1;
    for (int i = 0; i < d; i++) lim = lim * 10;
    ovf = (mag >= lim);
    res = '0;
    for (int i = 0; i < d; i++) begin
      res = res | ((ovf ? 64'd9 : (mag % 10)) << (4 * i));
      mag = mag / 10;
    end
    return res;
  endfunction

  task automatic driveIn(input int id, input logic s, input logic [63:0] v);
    case (id)
      0:       begin a_if.start = s; a_if.binary_in = v[7:0];  end
      1:       begin b_if.start = s; b_if.binary_in = v[7:0];  end
      default: begin c_if.start = s; c_if.binary_in = v[15:0]; end
    endcase
  endtask

  task automatic sampleOut(input int id, output logic b, output logic d, output logic [63:0] bcd,
                           output logic o, output logic s);
    case (id)
      0:       begin b = a_if.busy; d = a_if.done; bcd = 64'(a_if.bcd_out); o = a_if.overflow; s = a_if.sign_out; end
      1:       begin b = b_if.busy; d = b_if.done; bcd = 64'(b_if.bcd_out); o = b_if.overflow; s = b_if.sign_out; end
      default: begin b = c_if.busy; d = c_if.done; bcd = 64'(c_if.bcd_out); o = c_if.overflow; s = c_if.sign_out; end
    endcase
  endtask

  // One full conversion; chained=1 means start was already raised in the prior done cycle
  task automatic applyStimulus(input int id, input logic [63:0] value, input bit chained);
    int          w;
    int          d;
    int          cycles;
    logic        bz, dn, ov, sg, exp_ov, exp_sg;
    logic [63:0] bcd, exp_bcd;
    w = (id == 2) ? 16 : 8;
    d = (id == 0) ? 3 : ((id == 1) ? 2 : 5);
    if (!chained) begin
      @(posedge clk); #1;
      sampleOut(id, bz, dn, bcd, ov, sg);
      checkOutput($sformatf("idle_done_id%0d", id), 64'(dn), 64'd0);
      @(negedge clk);
      driveIn(id, 1'b1, value);
    end
    exp_bcd = refBcd(value, w, d, exp_ov, exp_sg);
    cycles = 0;
    dn = 1'b0;
    while (!dn && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
      sampleOut(id, bz, dn, bcd, ov, sg);
      if (cycles == 1) begin
        driveIn(id, 1'b0, 64'($urandom));
        checkOutput($sformatf("busy_after_accept_id%0d", id), 64'(bz), 64'd1);
      end
    end
    checkOutput($sformatf("latency_id%0d_v%0d", id, value), 64'(cycles), 64'(w + 1));
    checkOutput($sformatf("busy_at_done_id%0d", id), 64'(bz), 64'd0);
    checkOutput($sformatf("bcd_id%0d_v%0d", id, value), bcd, exp_bcd);
    checkOutput($sformatf("ovf_id%0d_v%0d", id, value), 64'(ov), 64'(exp_ov));
    checkOutput($sformatf("sign_id%0d_v%0d", id, value), 64'(sg), 64'(exp_sg));
  endtask

  // Directed and randomised sequence
  initial begin
    logic        bz, dn, ov, sg;
    logic [63:0] bcd;
    logic [63:0] chain_vals [5];
    int          done_seen;

    chain_vals = '{64'd0, 64'd9, 64'd10, 64'd99, 64'd100};
    reset = 1'b1;
    driveIn(0, 1'b0, 64'd0);
    driveIn(1, 1'b0, 64'd0);
    driveIn(2, 1'b0, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int id = 0; id < 3; id++) begin
      sampleOut(id, bz, dn, bcd, ov, sg);
      checkOutput($sformatf("reset_busy_id%0d", id), 64'(bz), 64'd0);
      checkOutput($sformatf("reset_done_id%0d", id), 64'(dn), 64'd0);
      checkOutput($sformatf("reset_bcd_id%0d", id), bcd, 64'd0);
      checkOutput($sformatf("reset_ovf_id%0d", id), 64'(ov), 64'd0);
    end
    reset = 1'b0;

    $display("[TB] directed conversions");
    applyStimulus(0, 64'd255, 1'b0);
    applyStimulus(0, 64'h80, 1'b0);
    applyStimulus(0, 64'hF6, 1'b0);

    $display("[TB] back-to-back chain");
    applyStimulus(0, chain_vals[0], 1'b0);
    for (int i = 1; i < 5; i++) begin
      driveIn(0, 1'b1, chain_vals[i]);
      applyStimulus(0, chain_vals[i], 1'b1);
    end

    $display("[TB] abort by reset");
    applyStimulus(0, 64'd255, 1'b0);
    @(negedge clk);
    driveIn(0, 1'b1, 64'd200);
    @(posedge clk); #1;
    driveIn(0, 1'b0, 64'd200);
    @(posedge clk); #1;
    @(posedge clk); #1;
    driveIn(0, 1'b1, 64'd7);
    @(posedge clk); #1;
    driveIn(0, 1'b0, 64'd7);
    sampleOut(0, bz, dn, bcd, ov, sg);
    checkOutput("busy_ignores_restart", 64'(bz), 64'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sampleOut(0, bz, dn, bcd, ov, sg);
    checkOutput("abort_busy", 64'(bz), 64'd0);
    checkOutput("abort_bcd", bcd, 64'd0);
    checkOutput("abort_ovf", 64'(ov), 64'd0);
    checkOutput("abort_sign", 64'(sg), 64'd0);
    done_seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      sampleOut(0, bz, dn, bcd, ov, sg);
      if (dn || bz) done_seen++;
    end
    checkOutput("abort_no_activity", 64'(done_seen), 64'd0);
    applyStimulus(0, 64'd7, 1'b0);

    $display("[TB] two-digit saturation");
    applyStimulus(1, 64'd100, 1'b0);
    applyStimulus(1, 64'd57, 1'b0);
    applyStimulus(1, 64'd99, 1'b0);
    applyStimulus(1, 64'd255, 1'b0);

    $display("[TB] sixteen-bit conversions");
    applyStimulus(2, 64'd65535, 1'b0);
    applyStimulus(2, 64'd0, 1'b0);
    applyStimulus(2, 64'h8000, 1'b0);

    $display("[TB] random conversions");
    for (int i = 0; i < 20; i++) applyStimulus(0, 64'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 64'($urandom_range(0, 255)), 1'b0);
    for (int i = 0; i < 8; i++)  applyStimulus(2, 64'($urandom_range(0, 65535)), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
